// File: rtl/sic_pkg.sv
// sic_pkg: shared SIC fetch types and constants.
package sic_pkg;

    localparam int OPCODE_WIDTH = 8;
    localparam int INSTR_LENGTH = 3;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        VALID
    } fetch_state_t;

    typedef struct packed {
        logic [OPCODE_WIDTH-1:0] opcode;
        logic                    index;
        logic [14:0]             address;
    } sic_instr_t;

endpackage

// File: rtl/sic_fetch_unit.sv
// sic_fetch_unit: PC, one-word instruction fetch and valid/ready hand-off to execute.
module sic_fetch_unit
    import sic_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 15,
    parameter int DATA_SIZE     = 24,
    parameter int START_ADDRESS = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] start_address,
    input  logic                     halt,
    input  logic                     redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_address,
    output logic                     mem_request,
    input  logic                     mem_grant,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    input  logic [DATA_SIZE-1:0]     mem_read_data,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [OPCODE_WIDTH-1:0]  instr_opcode,
    output logic                     instr_index,
    output logic [14:0]              instr_address,
    output logic [ADDRESS_WIDTH-1:0] instr_pc,
    output logic                     busy
);

    fetch_state_t             state, state_n;
    logic [ADDRESS_WIDTH-1:0] pc, pc_n, ipc;
    sic_instr_t               ir;
    logic                     capture;

    always_comb begin
        state_n = state;
        pc_n    = pc;
        capture = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = FETCH;
                    pc_n    = start_address;
                end
            end
            FETCH: begin
                if (halt) begin
                    state_n = IDLE;
                end else if (redirect_valid) begin
                    pc_n = redirect_address;
                end else if (mem_grant) begin
                    capture = 1'b1;
                    pc_n    = pc + ADDRESS_WIDTH'(INSTR_LENGTH);
                    state_n = VALID;
                end
            end
            VALID: begin
                // redirect takes the instruction away even when execute is ready
                if (redirect_valid) pc_n = redirect_address;
                if (redirect_valid || instr_ready) state_n = halt ? IDLE : FETCH;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            pc    <= ADDRESS_WIDTH'(START_ADDRESS);
            ir    <= '0;
            ipc   <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            if (capture) begin
                ir  <= sic_instr_t'(mem_read_data[23:0]);
                ipc <= pc;
            end
        end
    end

    assign mem_request   = state == FETCH;
    assign mem_address   = pc;
    assign instr_valid   = state == VALID;
    assign busy          = state != IDLE;
    assign instr_opcode  = ir.opcode;
    assign instr_index   = ir.index;
    assign instr_address = ir.address;
    assign instr_pc      = ipc;

endmodule

// File: tb/tb_sic_fetch_unit.sv
// tb_sic_fetch_unit: directed stimulus with a queue scoreboard checked by an independent monitor.
module tb_sic_fetch_unit;
    import sic_pkg::*;

    typedef struct packed {
        sic_instr_t  ins;
        logic [14:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [14:0] start_address = '0;
    logic        halt = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [14:0] redirect_address = '0;
    logic        mem_request;
    logic        mem_grant = 1'b1;
    logic [14:0] mem_address;
    logic [23:0] mem_read_data;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [7:0]  instr_opcode;
    logic        instr_index;
    logic [14:0] instr_address;
    logic [14:0] instr_pc;
    logic        busy;

    logic [7:0] mem [0:32767];
    exp_t       sb [$];
    int         checks = 0;
    int         errors = 0;

    sic_fetch_unit dut (
        .clk(clk), .reset(reset), .start(start), .start_address(start_address),
        .halt(halt), .redirect_valid(redirect_valid), .redirect_address(redirect_address),
        .mem_request(mem_request), .mem_grant(mem_grant), .mem_address(mem_address),
        .mem_read_data(mem_read_data), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_opcode(instr_opcode), .instr_index(instr_index), .instr_address(instr_address),
        .instr_pc(instr_pc), .busy(busy)
    );

    always #5 clk = ~clk;

    // big-endian 3-byte read, address wraps at 2^15
    assign mem_read_data = {mem[mem_address], mem[mem_address + 15'd1], mem[mem_address + 15'd2]};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [14:0] a, input logic [23:0] w, input logic [14:0] pc);
        mem[a]         = w[23:16];
        mem[a + 15'd1] = w[15:8];
        mem[a + 15'd2] = w[7:0];
        sb.push_back({w, pc});
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!reset && instr_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_instr", {instr_opcode, instr_index, instr_address, instr_pc}, '0);
                end else begin
                    chk("instr_fields", {instr_opcode, instr_index, instr_address, instr_pc}, sb[0]);
                    if (instr_ready || redirect_valid) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 8'h00;
        put(15'h0100, 24'h188123, 15'h0100);
        put(15'h0103, 24'h1C0045, 15'h0103);
        put(15'h0106, 24'h00FFFF, 15'h0106);
        put(15'h0200, 24'h280010, 15'h0200);
        put(15'h0203, 24'h3C8000, 15'h0203);
        put(15'h7FFE, 24'h548001, 15'h7FFE);
        put(15'h0001, 24'h0C1234, 15'h0001);
        step(2);
        chk("rst_busy", busy, 0);
        chk("rst_req", mem_request, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_addr", mem_address, 0);
        chk("rst_fields", {instr_opcode, instr_index, instr_address, instr_pc}, 0);
        reset = 1'b0;
        step(1);
        start = 1'b1;
        start_address = 15'h0100;
        step(1);
        start = 1'b0;
        chk("start_req", mem_request, 1);
        chk("start_addr", mem_address, 15'h0100);
        step(1);
        chk("grant_valid", instr_valid, 1);
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("stall_valid", instr_valid, 1);
            chk("stall_req", mem_request, 0);
        end
        instr_ready = 1'b1;
        mem_grant = 1'b0;
        step(1);
        instr_ready = 1'b0;
        chk("next_addr", mem_address, 15'h0103);
        chk("next_valid", instr_valid, 0);
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("nogrant_req", mem_request, 1);
            chk("nogrant_addr", mem_address, 15'h0103);
        end
        mem_grant = 1'b1;
        step(1);
        chk("late_grant_valid", instr_valid, 1);
        instr_ready = 1'b1;
        step(2);
        chk("b2b_valid", instr_valid, 1);
        redirect_valid = 1'b1;
        redirect_address = 15'h0200;
        step(1);
        redirect_valid = 1'b0;
        chk("redir_valid", instr_valid, 0);
        chk("redir_req", mem_request, 1);
        chk("redir_addr", mem_address, 15'h0200);
        step(4);
        chk("fetch_0206", mem_address, 15'h0206);
        redirect_valid = 1'b1;
        redirect_address = 15'h7FFE;
        step(1);
        redirect_valid = 1'b0;
        chk("fredir_req", mem_request, 1);
        chk("fredir_valid", instr_valid, 0);
        chk("fredir_addr", mem_address, 15'h7FFE);
        step(1);
        chk("wrap_valid", instr_valid, 1);
        step(1);
        chk("wrap_addr", mem_address, 15'h0001);
        instr_ready = 1'b0;
        step(1);
        halt = 1'b1;
        instr_ready = 1'b1;
        step(1);
        instr_ready = 1'b0;
        chk("halt_busy", busy, 0);
        chk("halt_req", mem_request, 0);
        chk("halt_valid", instr_valid, 0);
        redirect_valid = 1'b1;
        redirect_address = 15'h0500;
        step(1);
        chk("idle_redir_busy", busy, 0);
        redirect_valid = 1'b0;
        halt = 1'b0;
        mem_grant = 1'b0;
        start = 1'b1;
        start_address = 15'h0300;
        step(1);
        start_address = 15'h0400;
        step(1);
        start = 1'b0;
        chk("restart_req", mem_request, 1);
        chk("start_ignored", mem_address, 15'h0300);
        #2 reset = 1'b1;
        #1;
        chk("async_req", mem_request, 0);
        chk("async_busy", busy, 0);
        step(2);
        chk("async_addr", mem_address, 0);
        reset = 1'b0;
        step(1);
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
